vga_timing_gen: RTL

- Parametrised successor to the fixed 640x480 RGB scan block.
- Generates programmable horizontal/vertical timing, hs, vs and de.
- Provides a pixel clock-enable from a divider and a linear frame-buffer fetch address with configurable line stride.
- Sits between the video SRAM arbiter and the panel/TTL drivers; the fetch address feeds the video_mem address mux while the SRAM is idle.

---
 rtl/vga_timing_gen_if.sv | 36 +++
 rtl/vga_timing_gen.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: video timing bundle between generator and
// its consumers (panel drivers, fetch address mux, irq logic).
interface vga_timing_gen_if #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned HC_W   = 10,
  parameter int unsigned VC_W   = 10
);
  logic              enable;
  logic              pix_ce;
  logic              hs;
  logic              vs;
  logic              de;
  logic [ADDR_W-1:0] pix_addr;
  logic [HC_W-1:0]   hcnt;
  logic [VC_W-1:0]   vcnt;
  logic              line_start;
  logic              frame_start;
  logic              vblank_irq;
  logic [ADDR_W-1:0] fb_base_in;
  logic              fb_base_wr;
  logic              flip_done;

  modport master (
    input  enable, fb_base_in, fb_base_wr,
    output pix_ce, hs, vs, de, pix_addr,
    output hcnt, vcnt, line_start,
    output frame_start, vblank_irq, flip_done
  );

  modport slave (
    output enable, fb_base_in, fb_base_wr,
    input  pix_ce, hs, vs, de, pix_addr,
    input  hcnt, vcnt, line_start,
    input  frame_start, vblank_irq, flip_done
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: programmable VGA timing, pixel CE and fetch address.
// Define VGA_PAGE_FLIP_EN for frame-synchronous base address flipping.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned PIX_DIV  = 2,
  parameter int unsigned ADDR_W   = 24,
  parameter int unsigned STRIDE   = 640,
  parameter logic [ADDR_W-1:0] FB_BASE = '0
) (
  input logic clk,
  input logic rst,
  vga_timing_gen_if.master bus
);

  localparam int unsigned H_TOTAL =
    H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL =
    V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HC_W = $clog2(H_TOTAL);
  localparam int unsigned VC_W = $clog2(V_TOTAL);
  localparam int unsigned DIV_W =
    (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int unsigned HS_BEG = H_ACTIVE + H_FP;
  localparam int unsigned HS_END = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG = V_ACTIVE + V_FP;
  localparam int unsigned VS_END = VS_BEG + V_SYNC;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(STRIDE);

  logic [DIV_W-1:0]  div;
  logic [HC_W-1:0]   hcnt;
  logic [VC_W-1:0]   vcnt;
  logic              pix_ce;
  logic              hs;
  logic              vs;
  logic              de;
  logic              line_start;
  logic              frame_start;
  logic              vblank_irq;
  logic              flip_done;
  logic [ADDR_W-1:0] pix_addr;
  logic [ADDR_W-1:0] line_ptr;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] lp_cur;
  logic [31:0]       hw;
  logic [31:0]       vw;
  logic              div_last;
  logic              h_last;
  logic              v_last;
  logic              origin;
  logic              wrap_tick;
  logic              de_d;
  logic              hs_d;
  logic              vs_d;

  assign hw = 32'(hcnt);
  assign vw = 32'(vcnt);

  assign div_last = (32'(div) == PIX_DIV - 1);
  assign h_last   = (hw == H_TOTAL - 1);
  assign v_last   = (vw == V_TOTAL - 1);
  assign origin   = (hw == 0) && (vw == 0);
  assign wrap_tick =
    bus.enable && pix_ce && h_last && v_last;

  // Line pointer is reloaded from base at the frame origin.
  assign lp_cur = origin ? base : line_ptr;

  assign de_d = (hw < H_ACTIVE) && (vw < V_ACTIVE);
  assign hs_d = (hw >= HS_BEG) && (hw < HS_END);
  assign vs_d = (vw >= VS_BEG) && (vw < VS_END);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div         <= '0;
      pix_ce      <= 1'b0;
      hcnt        <= '0;
      vcnt        <= '0;
      de          <= 1'b0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      pix_addr    <= FB_BASE;
      line_ptr    <= FB_BASE;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      vblank_irq  <= 1'b0;
    end else if (!bus.enable) begin
      div         <= '0;
      pix_ce      <= 1'b0;
      hcnt        <= '0;
      vcnt        <= '0;
      de          <= 1'b0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      pix_addr    <= FB_BASE;
      line_ptr    <= FB_BASE;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      vblank_irq  <= 1'b0;
    end else begin
      div         <= div_last ? '0 : div + DIV_W'(1);
      pix_ce      <= div_last;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      vblank_irq  <= 1'b0;
      if (pix_ce) begin
        if (h_last) begin
          hcnt <= '0;
          vcnt <= v_last ? '0 : vcnt + VC_W'(1);
        end else begin
          hcnt <= hcnt + HC_W'(1);
        end
        de <= de_d;
        hs <= hs_d ? HS_POL : ~HS_POL;
        vs <= vs_d ? VS_POL : ~VS_POL;
        if (de_d)
          pix_addr <= lp_cur + ADDR_W'(hcnt);
        if (de_d && (hw == H_ACTIVE - 1))
          line_ptr <= lp_cur + STEP;
        else if (origin)
          line_ptr <= base;
        line_start  <= (hw == 0) && (vw < V_ACTIVE);
        frame_start <= origin;
        vblank_irq  <= (hw == 0) && (vw == V_ACTIVE);
      end
    end
  end

`ifdef VGA_PAGE_FLIP_EN
  logic              pend;
  logic [ADDR_W-1:0] pend_base;

  // A write landing on the wrap tick only arms the next frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base      <= FB_BASE;
      pend      <= 1'b0;
      pend_base <= FB_BASE;
      flip_done <= 1'b0;
    end else begin
      flip_done <= 1'b0;
      if (wrap_tick && pend) begin
        base      <= pend_base;
        pend      <= 1'b0;
        flip_done <= 1'b1;
      end
      if (bus.fb_base_wr) begin
        pend      <= 1'b1;
        pend_base <= bus.fb_base_in;
      end
    end
  end
`else
  logic unused_flip;

  assign base      = FB_BASE;
  assign flip_done = 1'b0;
  assign unused_flip =
    ^{bus.fb_base_in, bus.fb_base_wr, wrap_tick};
`endif

  assign bus.pix_ce      = pix_ce;
  assign bus.hs          = hs;
  assign bus.vs          = vs;
  assign bus.de          = de;
  assign bus.pix_addr    = pix_addr;
  assign bus.hcnt        = hcnt;
  assign bus.vcnt        = vcnt;
  assign bus.line_start  = line_start;
  assign bus.frame_start = frame_start;
  assign bus.vblank_irq  = vblank_irq;
  assign bus.flip_done   = flip_done;

endmodule
